id_stage_hs: RTL and testbench

- Parametrised successor of the instruction-decode stage for the 5-stage RISC-V pipeline.
- Contains:
  - NREG x XLEN register file with write-through bypass
  - full RV32I immediate generation, including U-type
  - control decode
  - early branch/jump resolution with signed and unsigned compares
  - ID/EX pipeline register with valid/ready handshake, stall bubble insertion and flush
- Sits between the IF/ID register and the EX stage. Drives the fetch redirect.

---
 rtl/id_stage_hs.sv | 215 +++++++++++++++++++++
 tb/tb_id_stage_hs.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hs.sv
// Instruction-decode stage: register file with write-through bypass, RV32I
// immediate generation, control decode, early branch/jump resolution and an
// ID/EX pipeline register with a valid/ready handshake.
module id_stage_hs #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] pc_in,
   input  logic [31:0]     instr_in,
   input  logic            stall,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic [1:0]      fwd_a,
   input  logic [1:0]      fwd_b,
   input  logic [XLEN-1:0] mem_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic [AW-1:0]   out_rd,
   output logic [AW-1:0]   out_rs1,
   output logic [AW-1:0]   out_rs2,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [7:0]      out_ctl,
   output logic            out_jal,
   output logic            out_jalr,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic [XLEN-1:0]   r_rf [NREG];
   logic              r_valid;
   logic [XLEN-1:0]   r_pc, r_rs1_data, r_rs2_data, r_imm;
   logic [AW-1:0]     r_rd, r_rs1, r_rs2;
   logic [2:0]        r_funct3;
   logic [6:0]        r_funct7;
   logic [7:0]        r_ctl;
   logic              r_jal, r_jalr;

   logic [6:0]        w_opcode;
   logic [2:0]        w_funct3;
   logic [AW-1:0]     w_rs1_idx, w_rs2_idx, w_rd_idx;
   logic              w_rs2_zero, w_is_branch, w_is_jal, w_is_jalr, w_taken;
   logic [7:0]        w_ctl;
   logic signed [31:0] w_imm32;
   logic [XLEN-1:0]   w_imm, w_rs1_data, w_rs2_data, w_op_a, w_op_b, w_jalr_sum;
   logic              w_transfer;

   assign w_opcode  = instr_in[6:0];
   assign w_funct3  = instr_in[14:12];
   assign w_rd_idx  = instr_in[7 +: AW];
   assign w_rs1_idx = instr_in[15 +: AW];
   assign w_rs2_idx = w_rs2_zero ? {AW{1'b0}} : instr_in[20 +: AW];
   assign w_imm     = XLEN'(w_imm32);

   // Opcode decode: control word, immediate format, rs2 suppression, jump flags.
   always_comb begin
      w_ctl       = 8'h00;
      w_imm32     = 32'sd0;
      w_rs2_zero  = 1'b0;
      w_is_branch = 1'b0;
      w_is_jal    = 1'b0;
      w_is_jalr   = 1'b0;
      case (w_opcode)
         OP_LOAD: begin
            w_ctl = 8'hF0; w_rs2_zero = 1'b1;
            w_imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
         end
         OP_STORE: begin
            w_ctl = 8'h88;
            w_imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
         end
         OP_OP: w_ctl = 8'h22;
         OP_OPIMM: begin
            w_ctl = 8'hA3; w_rs2_zero = 1'b1;
            w_imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
         end
         OP_BRANCH: begin
            w_ctl = 8'h05; w_is_branch = 1'b1;
            w_imm32 = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
         end
         OP_JAL: begin
            w_ctl = 8'h20; w_rs2_zero = 1'b1; w_is_jal = 1'b1;
            w_imm32 = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
         end
         OP_JALR: begin
            w_ctl = 8'h20; w_rs2_zero = 1'b1; w_is_jalr = 1'b1;
            w_imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
         end
         OP_LUI, OP_AUIPC: begin
            w_ctl = 8'hA0; w_rs2_zero = 1'b1;
            w_imm32 = {instr_in[31:12], 12'h000};
         end
         default: begin
            w_ctl = 8'h00;
         end
      endcase
   end

   // Register file read with optional forwarding of a same-cycle writeback.
   always_comb begin
      w_rs1_data = r_rf[w_rs1_idx];
      w_rs2_data = r_rf[w_rs2_idx];
      if (BYPASS == 1 && wb_we && wb_rd == w_rs1_idx && w_rs1_idx != {AW{1'b0}}) begin
         w_rs1_data = wb_data;
      end else begin
         w_rs1_data = r_rf[w_rs1_idx];
      end
      if (BYPASS == 1 && wb_we && wb_rd == w_rs2_idx && w_rs2_idx != {AW{1'b0}}) begin
         w_rs2_data = wb_data;
      end else begin
         w_rs2_data = r_rf[w_rs2_idx];
      end
   end

   // Compare operand selection and branch/jump taken evaluation.
   always_comb begin
      w_op_a  = (fwd_a == 2'b10) ? mem_data : ((fwd_a == 2'b01) ? wb_data : w_rs1_data);
      w_op_b  = (fwd_b == 2'b10) ? mem_data : ((fwd_b == 2'b01) ? wb_data : w_rs2_data);
      w_taken = 1'b0;
      if (w_is_jal || w_is_jalr) begin
         w_taken = 1'b1;
      end else if (w_is_branch) begin
         case (w_funct3)
            3'b000:  w_taken = (w_op_a == w_op_b);
            3'b001:  w_taken = (w_op_a != w_op_b);
            3'b100:  w_taken = ($signed(w_op_a) <  $signed(w_op_b));
            3'b101:  w_taken = ($signed(w_op_a) >= $signed(w_op_b));
            3'b110:  w_taken = (w_op_a <  w_op_b);
            3'b111:  w_taken = (w_op_a >= w_op_b);
            default: w_taken = 1'b0;
         endcase
      end else begin
         w_taken = 1'b0;
      end
   end

   assign w_jalr_sum  = w_op_a + w_imm;
   assign redirect_pc = w_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (pc_in + w_imm);
   assign redirect    = in_valid && !stall && !flush && w_taken;
   assign in_ready    = !stall && !flush && (!r_valid || out_ready);
   assign w_transfer  = in_valid && in_ready;

   // Register file write; entry 0 is never written so x0 stays zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= {XLEN{1'b0}};
      end else if (wb_we && wb_rd != {AW{1'b0}}) begin
         r_rf[wb_rd] <= wb_data;
      end
   end

   // ID/EX register: flush, then transfer, then drain to a bubble, else hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;        r_pc <= {XLEN{1'b0}};
         r_rs1_data <= {XLEN{1'b0}}; r_rs2_data <= {XLEN{1'b0}};
         r_imm <= {XLEN{1'b0}};  r_rd <= {AW{1'b0}};
         r_rs1 <= {AW{1'b0}};    r_rs2 <= {AW{1'b0}};
         r_funct3 <= 3'b000;     r_funct7 <= 7'b0000000;
         r_ctl <= 8'h00;         r_jal <= 1'b0;  r_jalr <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_ctl   <= 8'h00;
      end else if (w_transfer) begin
         r_valid <= 1'b1;        r_pc <= pc_in;
         r_rs1_data <= w_rs1_data; r_rs2_data <= w_rs2_data;
         r_imm <= w_imm;         r_rd <= w_rd_idx;
         r_rs1 <= w_rs1_idx;     r_rs2 <= w_rs2_idx;
         r_funct3 <= w_funct3;   r_funct7 <= instr_in[31:25];
         r_ctl <= w_ctl;         r_jal <= w_is_jal;  r_jalr <= w_is_jalr;
      end else if (out_ready) begin
         r_valid <= 1'b0;
         r_ctl   <= 8'h00;
      end else begin
         r_valid <= r_valid;
      end
   end

   assign out_valid    = r_valid;
   assign out_pc       = r_pc;
   assign out_rs1_data = r_rs1_data;
   assign out_rs2_data = r_rs2_data;
   assign out_imm      = r_imm;
   assign out_rd       = r_rd;
   assign out_rs1      = r_rs1;
   assign out_rs2      = r_rs2;
   assign out_funct3   = r_funct3;
   assign out_funct7   = r_funct7;
   assign out_ctl      = r_ctl;
   assign out_jal      = r_jal;
   assign out_jalr     = r_jalr;

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed bench for id_stage_hs: a default 32-bit/32-register instance and a
// 64-bit/16-register instance, each scenario in its own task.
module tb_id_stage_hs;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, stall, flush, wb_we, out_valid, out_ready;
   logic [31:0] pc_in, instr_in, wb_data, mem_data;
   logic [4:0]  wb_rd;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm, redirect_pc;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [7:0]  out_ctl;
   logic        out_jal, out_jalr, redirect;

   logic        in_valid_b, in_ready_b, wb_we_b, out_valid_b, out_ready_b, redirect_b;
   logic        out_jal_b, out_jalr_b;
   logic [31:0] instr_b;
   logic [63:0] pc_b, wb_data_b, mem_data_b;
   logic [63:0] out_pc_b, out_rs1_data_b, out_rs2_data_b, out_imm_b, redirect_pc_b;
   logic [3:0]  wb_rd_b, out_rd_b, out_rs1_b, out_rs2_b;
   logic [2:0]  out_funct3_b;
   logic [6:0]  out_funct7_b;
   logic [7:0]  out_ctl_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_stage_hs u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .pc_in(pc_in), .instr_in(instr_in), .stall(stall), .flush(flush),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_ctl(out_ctl),
      .out_jal(out_jal), .out_jalr(out_jalr), .redirect(redirect), .redirect_pc(redirect_pc)
   );

   id_stage_hs #(.XLEN(64), .NREG(16), .BYPASS(1)) u_dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .pc_in(pc_b), .instr_in(instr_b), .stall(1'b0), .flush(1'b0),
      .wb_we(wb_we_b), .wb_rd(wb_rd_b), .wb_data(wb_data_b), .fwd_a(2'b00), .fwd_b(2'b00),
      .mem_data(mem_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_pc(out_pc_b), .out_rs1_data(out_rs1_data_b), .out_rs2_data(out_rs2_data_b),
      .out_imm(out_imm_b), .out_rd(out_rd_b), .out_rs1(out_rs1_b), .out_rs2(out_rs2_b),
      .out_funct3(out_funct3_b), .out_funct7(out_funct7_b), .out_ctl(out_ctl_b),
      .out_jal(out_jal_b), .out_jalr(out_jalr_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b)
   );

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; wb_we = 1'b0;
      wb_rd = 5'd0; wb_data = 32'h0; fwd_a = 2'b00; fwd_b = 2'b00; mem_data = 32'h0;
      out_ready = 1'b1; pc_in = 32'h0; instr_in = 32'h0;
      in_valid_b = 1'b0; wb_we_b = 1'b0; wb_rd_b = 4'd0; wb_data_b = 64'h0;
      mem_data_b = 64'h0; out_ready_b = 1'b1; pc_b = 64'h0; instr_b = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
      n_checks++; if (out_ctl !== 8'h00) begin n_fail++; $display("FAIL reset_ctl: got %h exp 00", out_ctl); end
      n_checks++; if ({out_pc, out_imm, out_rs1_data} !== 96'h0) begin n_fail++; $display("FAIL reset_data: got %h %h %h exp 0", out_pc, out_imm, out_rs1_data); end
      n_checks++; if (out_valid_b !== 1'b0 || out_imm_b !== 64'h0) begin n_fail++; $display("FAIL reset_b: got %b %h exp 0 0", out_valid_b, out_imm_b); end
      reset = 1'b1;
      step();
      // addi x1, x5, 1
      in_valid = 1'b1; pc_in = 32'h40; instr_in = 32'h00128093;
      step();
      n_checks++; if (out_valid !== 1'b1 || out_rs1_data !== 32'h0) begin n_fail++; $display("FAIL addi_x5: got v=%b d=%h exp 1 0", out_valid, out_rs1_data); end
      n_checks++; if (out_ctl !== 8'hA3 || out_imm !== 32'h1) begin n_fail++; $display("FAIL addi_dec: got ctl=%h imm=%h exp a3 1", out_ctl, out_imm); end
      n_checks++; if (out_rs2 !== 5'd0 || out_rs1 !== 5'd5 || out_rd !== 5'd1) begin n_fail++; $display("FAIL addi_idx: got %0d %0d %0d exp 0 5 1", out_rs2, out_rs1, out_rd); end
      in_valid = 1'b0;
   endtask

   task automatic test_bypass();
      // add x1, x3, x0 with x3 written in the same cycle
      in_valid = 1'b1; instr_in = 32'h000180B3; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
      step();
      n_checks++; if (out_rs1_data !== 32'h1234) begin n_fail++; $display("FAIL bypass_data: got %h exp 1234", out_rs1_data); end
      n_checks++; if (out_ctl !== 8'h22 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_ctl: got %h %b exp 22 1", out_ctl, out_valid); end
      // add x2, x3, x0 reads the stored value
      wb_we = 1'b0; instr_in = 32'h00018133;
      step();
      n_checks++; if (out_rs1_data !== 32'h1234) begin n_fail++; $display("FAIL rf_stored: got %h exp 1234", out_rs1_data); end
      // write to x0 must be ignored, including the bypass path
      wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD; instr_in = 32'h00000133;
      step();
      n_checks++; if (out_rs1_data !== 32'h0) begin n_fail++; $display("FAIL x0_bypass: got %h exp 0", out_rs1_data); end
      wb_we = 1'b0;
      step();
      n_checks++; if (out_rs1_data !== 32'h0) begin n_fail++; $display("FAIL x0_write: got %h exp 0", out_rs1_data); end
      in_valid = 1'b0;
   endtask

   task automatic test_branch();
      in_valid = 1'b1; pc_in = 32'h100; fwd_a = 2'b10; fwd_b = 2'b01;
      mem_data = 32'hFFFFFFFF; wb_data = 32'h1; wb_we = 1'b0;
      instr_in = 32'h0020E463; // bltu
      @(negedge clk);
      n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL bltu_taken: got %b exp 0", redirect); end
      step();
      instr_in = 32'h0020C463; // blt
      @(negedge clk);
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h108) begin n_fail++; $display("FAIL blt_taken: got %b %h exp 1 108", redirect, redirect_pc); end
      step();
      instr_in = 32'h0020F463; // bgeu
      @(negedge clk);
      n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL bgeu_taken: got %b exp 1", redirect); end
      step();
      instr_in = 32'h0020A463; // funct3 010
      @(negedge clk);
      n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL f3_010: got %b exp 0", redirect); end
      step();
      in_valid = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
   endtask

   task automatic test_jalr();
      wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h203;
      step();
      wb_we = 1'b0; in_valid = 1'b1; pc_in = 32'h500; instr_in = 32'h000280E7; // jalr x1, 0(x5)
      @(negedge clk);
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h202) begin n_fail++; $display("FAIL jalr_rf: got %b %h exp 1 202", redirect, redirect_pc); end
      step();
      fwd_a = 2'b10; mem_data = 32'h305;
      @(negedge clk);
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h304) begin n_fail++; $display("FAIL jalr_fwd: got %b %h exp 1 304", redirect, redirect_pc); end
      step();
      n_checks++; if (out_jalr !== 1'b1 || out_ctl !== 8'h20 || out_jal !== 1'b0) begin n_fail++; $display("FAIL jalr_latch: got %b %h %b exp 1 20 0", out_jalr, out_ctl, out_jal); end
      stall = 1'b1;
      @(negedge clk);
      n_checks++; if (redirect !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL jalr_stall: got %b %b exp 0 0", redirect, in_ready); end
      step();
      stall = 1'b0; fwd_a = 2'b00; in_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1; pc_in = 32'h600; instr_in = 32'h00402203; // lw x4, 4(x0)
      step();
      out_ready = 1'b0; instr_in = 32'h000180B3; pc_in = 32'h604;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b exp 0", i, in_ready); end
         step();
         n_checks++; if (out_valid !== 1'b1 || out_ctl !== 8'hF0 || out_pc !== 32'h600 || out_imm !== 32'h4 || out_rd !== 5'd4)
            begin n_fail++; $display("FAIL bp_hold%0d: got v=%b ctl=%h pc=%h imm=%h rd=%0d exp 1 f0 600 4 4", i, out_valid, out_ctl, out_pc, out_imm, out_rd); end
      end
      stall = 1'b1; out_ready = 1'b1;
      step();
      n_checks++; if (out_valid !== 1'b0 || out_ctl !== 8'h00) begin n_fail++; $display("FAIL stall_bubble: got %b %h exp 0 00", out_valid, out_ctl); end
      stall = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_flush();
      in_valid = 1'b1; pc_in = 32'h200; instr_in = 32'h010000EF; // jal x1, 16
      @(negedge clk);
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h210) begin n_fail++; $display("FAIL jal_redirect: got %b %h exp 1 210", redirect, redirect_pc); end
      step();
      n_checks++; if (out_jal !== 1'b1 || out_imm !== 32'h10 || out_rs2 !== 5'd0 || out_valid !== 1'b1)
         begin n_fail++; $display("FAIL jal_latch: got %b %h %0d %b exp 1 10 0 1", out_jal, out_imm, out_rs2, out_valid); end
      flush = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL flush_comb: got %b %b exp 0 0", in_ready, redirect); end
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", out_valid); end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_wide_narrow();
      in_valid_b = 1'b1; pc_b = 64'h1000; instr_b = 32'h800007B7; // lui x15, 0x80000
      step();
      n_checks++; if (out_imm_b !== 64'hFFFFFFFF80000000) begin n_fail++; $display("FAIL lui64_imm: got %h exp ffffffff80000000", out_imm_b); end
      n_checks++; if (out_ctl_b !== 8'hA0 || out_rd_b !== 4'd15) begin n_fail++; $display("FAIL lui64_dec: got %h %0d exp a0 15", out_ctl_b, out_rd_b); end
      in_valid_b = 1'b0; wb_we_b = 1'b1; wb_rd_b = 4'd3; wb_data_b = 64'h55;
      step();
      wb_we_b = 1'b0; in_valid_b = 1'b1; instr_b = 32'h000980B3; // rs1 field 19 truncates to 3
      step();
      n_checks++; if (out_rs1_b !== 4'd3 || out_rs1_data_b !== 64'h55) begin n_fail++; $display("FAIL nreg16_trunc: got %0d %h exp 3 55", out_rs1_b, out_rs1_data_b); end
      in_valid_b = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_branch();
      test_jalr();
      test_backpressure();
      test_flush();
      test_wide_narrow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
